// File: rtl/ip_tile_host_bridge_pkg.sv
// Shared register map, FSM state encoding and STATUS bit layout for the tile host bridge.
package ip_tile_host_bridge_pkg;

  localparam logic [2:0] RegDataA  = 3'd0;
  localparam logic [2:0] RegDataB  = 3'd1;
  localparam logic [2:0] RegCsrIn  = 3'd2;
  localparam logic [2:0] RegCsrOut = 3'd3;
  localparam logic [2:0] RegDataC  = 3'd4;
  localparam logic [2:0] RegStatus = 3'd5;
  localparam logic [2:0] RegCtrl   = 3'd6;
  localparam logic [2:0] RegRsvd   = 3'd7;

  localparam int unsigned StatStateLsb    = 0;
  localparam int unsigned StatCmdPending  = 2;
  localparam int unsigned StatResultValid = 3;
  localparam int unsigned StatTimeout     = 4;
  localparam int unsigned StatOverrun     = 5;
  localparam int unsigned StatBusyErr     = 6;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCmdPend = 2'd1,
    StWaitRes = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/ip_tile_host_fsm.sv
// Command handshake FSM with a per-state wait counter that aborts a stalled phase.
module ip_tile_host_fsm
  import ip_tile_host_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       launch,
  input  logic       csr_in_re,
  input  logic       csr_out_we,
  output fsm_state_e state,
  output logic       timeout_evt
);

  // Counter value seen on the last cycle before the phase is abandoned.
  localparam logic [7:0] WaitLimit = 8'(TIMEOUT_CYCLES - 1);

  fsm_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    timeout_evt = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (launch) state_d = StIdle == StIdle ? StCmdPend : StIdle;
      end
      StCmdPend: begin
        if (csr_in_re && csr_out_we) begin
          state_d = StIdle;
        end else if (csr_in_re) begin
          state_d = StWaitRes;
        end else if (cnt_q == WaitLimit) begin
          timeout_evt = 1'b1;
          state_d     = StIdle;
        end
      end
      StWaitRes: begin
        if (csr_out_we) begin
          state_d = StIdle;
        end else if (cnt_q == WaitLimit) begin
          timeout_evt = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    cnt_d = (state_d != state_q || state_q == StIdle) ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/ip_tile_host_bridge.sv
// Host bus register file bridging to a compute tile's command/result CSR handshake.
module ip_tile_host_bridge
  import ip_tile_host_bridge_pkg::*;
#(
  parameter int unsigned CSR_IN_WIDTH   = 16,
  parameter int unsigned CSR_OUT_WIDTH  = 16,
  parameter int unsigned REG_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     bus_req,
  input  logic                     bus_we,
  input  logic [2:0]               bus_addr,
  input  logic [REG_WIDTH-1:0]     bus_wdata,
  output logic [REG_WIDTH-1:0]     bus_rdata,
  output logic                     bus_ack,
  output logic [CSR_IN_WIDTH-1:0]  csr_in,
  input  logic                     csr_in_re,
  output logic [REG_WIDTH-1:0]     data_reg_a,
  output logic [REG_WIDTH-1:0]     data_reg_b,
  input  logic [CSR_OUT_WIDTH-1:0] csr_out,
  input  logic                     csr_out_we,
  input  logic [REG_WIDTH-1:0]     data_reg_c
);

  logic [REG_WIDTH-1:0]     data_a_q, data_b_q, data_c_q, rdata_q, rdata_d, status_w;
  logic [CSR_IN_WIDTH-1:0]  csr_in_q;
  logic [CSR_OUT_WIDTH-1:0] csr_out_q;
  logic                     ack_q;
  logic                     result_valid_q, result_valid_d;
  logic                     timeout_q, timeout_d;
  logic                     overrun_q, overrun_d;
  logic                     busy_err_q, busy_err_d;
  logic                     wr, rd, wr_csr_in, launch, flag_clr, timeout_evt;
  fsm_state_e               state;

  assign wr        = bus_req & bus_we;
  assign rd        = bus_req & ~bus_we;
  assign wr_csr_in = wr && (bus_addr == RegCsrIn);
  assign launch    = wr_csr_in && (state == StIdle);
  assign flag_clr  = wr && (bus_addr == RegCtrl) && bus_wdata[0];

  ip_tile_host_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk        (clk),
    .arst_n     (arst_n),
    .launch     (launch),
    .csr_in_re  (csr_in_re),
    .csr_out_we (csr_out_we),
    .state      (state),
    .timeout_evt(timeout_evt)
  );

  always_comb begin
    status_w                             = '0;
    status_w[StatStateLsb +: 2]          = state;
    status_w[StatCmdPending]             = (state == StCmdPend);
    status_w[StatResultValid]            = result_valid_q;
    status_w[StatTimeout]                = timeout_q;
    status_w[StatOverrun]                = overrun_q;
    status_w[StatBusyErr]                = busy_err_q;
  end

  // A set event wins over a coincident CTRL clear; a capture wins over a CSR_OUT read.
  always_comb begin
    result_valid_d = result_valid_q;
    if (csr_out_we) begin
      result_valid_d = 1'b1;
    end else if (rd && bus_addr == RegCsrOut) begin
      result_valid_d = 1'b0;
    end
    timeout_d  = (timeout_q & ~flag_clr) | timeout_evt;
    overrun_d  = (overrun_q & ~flag_clr) | (csr_out_we & result_valid_q);
    busy_err_d = (busy_err_q & ~flag_clr) | (wr_csr_in & (state != StIdle));
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      unique case (bus_addr)
        RegDataA:  rdata_d = data_a_q;
        RegDataB:  rdata_d = data_b_q;
        RegCsrIn:  rdata_d = REG_WIDTH'(csr_in_q);
        RegCsrOut: rdata_d = REG_WIDTH'(csr_out_q);
        RegDataC:  rdata_d = data_c_q;
        RegStatus: rdata_d = status_w;
        RegCtrl:   rdata_d = '0;
        RegRsvd:   rdata_d = '0;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      data_a_q       <= '0;
      data_b_q       <= '0;
      csr_in_q       <= '0;
      csr_out_q      <= '0;
      data_c_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      overrun_q      <= 1'b0;
      busy_err_q     <= 1'b0;
      ack_q          <= 1'b0;
      rdata_q        <= '0;
    end else begin
      if (wr && bus_addr == RegDataA) data_a_q <= bus_wdata;
      if (wr && bus_addr == RegDataB) data_b_q <= bus_wdata;
      if (launch) csr_in_q <= bus_wdata[CSR_IN_WIDTH-1:0];
      if (csr_out_we) begin
        csr_out_q <= csr_out;
        data_c_q  <= data_reg_c;
      end
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
      overrun_q      <= overrun_d;
      busy_err_q     <= busy_err_d;
      ack_q          <= bus_req;
      rdata_q        <= rdata_d;
    end
  end

  assign bus_ack    = ack_q;
  assign bus_rdata  = rdata_q;
  assign csr_in     = csr_in_q;
  assign data_reg_a = data_a_q;
  assign data_reg_b = data_b_q;

endmodule

// File: doc/ip_tile_host_bridge.md
IP_TILE_HOST_BRIDGE -- requirements
Module: ip_tile_host_bridge

Interface
REQ-001 SHALL have parameter CSR_IN_WIDTH, default 16, tile command CSR width.
REQ-002 SHALL have parameter CSR_OUT_WIDTH, default 16, tile status CSR width.
REQ-003 SHALL have parameter REG_WIDTH, default 32, data register and bus width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum wait per handshake phase.
REQ-005 SHALL use one clock and an asynchronous active-low reset; the ports are listed below.
- clk  in  1  sole clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- bus_req  in  1  single-cycle host access strobe.
- bus_we  in  1  1=write, 0=read.
- bus_addr  in  3  word register index.
- bus_wdata  in  REG_WIDTH  write data.
- bus_rdata  out  REG_WIDTH  read data, valid with bus_ack.
- bus_ack  out  1  access complete.
- csr_in  out  CSR_IN_WIDTH  command to tile.
- csr_in_re  in  1  tile consumed csr_in (pulse).
- data_reg_a  out  REG_WIDTH  operand A to tile.
- data_reg_b  out  REG_WIDTH  operand B to tile.
- csr_out  in  CSR_OUT_WIDTH  tile status/result CSR.
- csr_out_we  in  1  tile result strobe (pulse).
- data_reg_c  in  REG_WIDTH  tile result data, valid with csr_out_we.

Function
REQ-006 SHALL use this register map: 0 DATA_A (RW), 1 DATA_B (RW), 2 CSR_IN (RW, a write launches a command), 3 CSR_OUT (RO, a read clears result_valid), 4 DATA_C (RO), 5 STATUS (RO), 6 CTRL (WO, bit0 write-1 clears the sticky flags), 7 reserved (reads 0, writes ignored).
REQ-007 SHALL drive bus_ack for exactly one cycle, registered one cycle after bus_req; bus_rdata SHALL be valid in the same cycle as bus_ack and 0 otherwise.
REQ-008 SHALL drive data_reg_a, data_reg_b and csr_in directly from flops; a DATA_A or DATA_B write SHALL be visible on the tile port on the cycle after bus_req.
REQ-009 SHALL implement FSM states IDLE, CMD_PEND and WAIT_RES.
REQ-010 IDLE to CMD_PEND: on a CSR_IN write, the new csr_in value takes effect on the same edge.
REQ-011 CMD_PEND to WAIT_RES: on csr_in_re.
REQ-012 CMD_PEND to IDLE: on csr_in_re and csr_out_we asserted in the same cycle, with the result captured.
REQ-013 WAIT_RES to IDLE: on csr_out_we.
REQ-014 SHALL reset an 8-bit wait counter on every state entry; reaching TIMEOUT_CYCLES in CMD_PEND or WAIT_RES SHALL set sticky timeout and return to IDLE.
REQ-015 On csr_out_we in any state SHALL capture csr_out and data_reg_c and set result_valid; if result_valid was already 1, SHALL set sticky overrun.
REQ-016 A CSR_OUT read coinciding with csr_out_we SHALL leave result_valid at 1 and SHALL return the old value.
REQ-017 A CSR_IN write outside IDLE SHALL be ignored (csr_in unchanged) and SHALL set sticky busy_err.
REQ-018 STATUS SHALL be {zeros, busy_err[6], overrun[5], timeout[4], result_valid[3], cmd_pending[2], state[1:0]}; cmd_pending=1 only in CMD_PEND; state encoding IDLE=0, CMD_PEND=1, WAIT_RES=2.
REQ-019 A CTRL clear coinciding with a flag-setting event SHALL leave that flag set.

Reset
REQ-020 On arst_n=0 SHALL asynchronously zero every register, all outputs, result_valid and all sticky flags, and force state IDLE.
REQ-021 Reset mid-handshake SHALL abandon the command with no flag recorded; the first post-reset bus access SHALL be acked normally.

Structure
REQ-022 The register index constants, the FSM state enum and the STATUS bit positions SHALL live in package ip_tile_host_bridge_pkg.
REQ-023 Bus decode and register file SHALL be a single module; the handshake FSM plus timeout counter MAY be sub-module ip_tile_host_fsm.

Verification
REQ-024 Write DATA_A=0x0000000A (ADD, A=10), DATA_B=5, CSR_IN=1; responder pulses csr_in_re at +2 and csr_out_we with data_reg_c=15 at +4 -> DATA_C reads 15, STATUS result_valid=1 and state=0; a CSR_OUT read clears result_valid.
REQ-025 CSR_IN write, no csr_in_re for 255 cycles -> STATUS timeout=1, state=0; CTRL=1 -> timeout=0.
REQ-026 Second CSR_IN write while in CMD_PEND -> csr_in keeps the first value, busy_err=1.
REQ-027 Two csr_out_we pulses (DIV 40/5 giving 8, then 15/0 giving 0) without a CSR_OUT read -> DATA_C=0, overrun=1.
REQ-028 csr_in_re and csr_out_we in the same cycle in CMD_PEND -> next cycle state=IDLE, result_valid=1.
REQ-029 arst_n low during WAIT_RES -> all outputs 0, STATUS=0; a subsequent read of reserved index 7 is acked with data 0.
